// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register and sticky error flags.
// io_valid rises one cycle after the stop-bit sample; a byte arriving while the holding register is full and not consumed is dropped.
module uart_rx #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rxd,
    output logic [7:0] io_data,
    output logic       io_valid,
    input  logic       io_ready,
    input  logic       io_clear,
    output logic       io_frame_error,
    output logic       io_overrun
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic          r_sync1;
    logic          r_rx_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_error;
    logic          r_overrun;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_load;
    logic          w_ovr_set;
    logic          w_ferr_set;
    logic          w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ovr_set   = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                        // A consumer draining the old byte this cycle frees the slot for the new one.
                        if (!r_valid || io_ready) begin
                            w_load = 1'b1;
                        end else begin
                            w_ovr_set = 1'b1;
                        end
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_rx_s        <= 1'b1;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sync1 <= io_rxd;
            r_rx_s  <= r_sync1;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            if (w_load) begin
                r_data  <= w_shift_nxt;
                r_valid <= 1'b1;
            end else if (r_valid && io_ready) begin
                r_valid <= 1'b0;
            end
            if (w_ferr_set) begin
                r_frame_error <= 1'b1;
            end else if (io_clear) begin
                r_frame_error <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (io_clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign io_data        = r_data;
    assign io_valid       = r_valid;
    assign io_frame_error = r_frame_error;
    assign io_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; a scoreboard queue holds the bytes expected at the handshake.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       io_rxd   = 1'b1;
    logic       io_ready = 1'b1;
    logic       io_clear = 1'b0;
    logic [7:0] io_data;
    logic       io_valid;
    logic       io_frame_error;
    logic       io_overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    logic       vhist[0:99];
    logic [7:0] dhist[0:99];
    logic       ohist[0:99];
    logic       fhist[0:99];

    uart_rx #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_rxd        (io_rxd),
        .io_data       (io_data),
        .io_valid      (io_valid),
        .io_ready      (io_ready),
        .io_clear      (io_clear),
        .io_frame_error(io_frame_error),
        .io_overrun    (io_overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives nbits bit-times of a frame starting at a negedge; records outputs each cycle.
    // Index k of the history is the value after posedge k, posedge 0 being the first to see the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits, input int ready_at);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            io_rxd = bits[i];
            for (int j = 0; j < CPB; j++) begin
                @(negedge clock);
                vhist[i*CPB+j] = io_valid;
                dhist[i*CPB+j] = io_data;
                ohist[i*CPB+j] = io_overrun;
                fhist[i*CPB+j] = io_frame_error;
                if (i*CPB+j == ready_at) io_ready = 1'b1;
            end
        end
    endtask

    // Scoreboard: a handshake completes at the posedge following this sample point.
    always @(negedge clock) begin
        logic [7:0] exp_b;
        #1;
        if (!reset && io_valid === 1'b1 && io_ready === 1'b1) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                check("sb_data", {24'd0, io_data}, {24'd0, exp_b});
            end
        end
    end

    initial begin
        int first;
        int ones;

        #1;
        check("rst_data", {24'd0, io_data}, 32'd0);
        check("rst_valid", 32'(io_valid), 32'd0);
        check("rst_ferr", 32'(io_frame_error), 32'd0);
        check("rst_ovr", 32'(io_overrun), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single byte: one-cycle pulse 97 cycles after the start edge
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 10, -1);
        first = -1;
        ones  = 0;
        for (int k = 0; k < 100; k++) begin
            if (vhist[k] === 1'b1) begin
                ones++;
                if (first < 0) first = k;
            end
        end
        check("t1_first_valid_cycle", 32'(first), 32'd97);
        check("t1_pulse_width", 32'(ones), 32'd1);
        check("t1_ferr", 32'(io_frame_error), 32'd0);
        check("t1_ovr", 32'(io_overrun), 32'd0);
        repeat (5) @(negedge clock);

        // Overrun with the consumer stalled, then clear
        io_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 10, -1);
        send_frame(8'h3C, 1'b1, 10, -1);
        check("t2_ovr_before_stop", 32'(ohist[96]), 32'd0);
        check("t2_ovr_after_stop", 32'(ohist[97]), 32'd1);
        check("t2_valid_held", 32'(io_valid), 32'd1);
        check("t2_data_held", {24'd0, io_data}, 32'h0000_00A5);
        io_clear = 1'b1;
        @(negedge clock);
        io_clear = 1'b0;
        check("t2_ovr_cleared", 32'(io_overrun), 32'd0);
        check("t2_data_after_clear", {24'd0, io_data}, 32'h0000_00A5);
        io_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("t2_valid_drained", 32'(io_valid), 32'd0);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // False start: 3-cycle glitch, then a real frame to show the receiver is idle again
        io_rxd = 1'b0;
        repeat (3) @(negedge clock);
        io_rxd = 1'b1;
        repeat (30) @(negedge clock);
        check("t3_no_valid", 32'(io_valid), 32'd0);
        check("t3_ferr", 32'(io_frame_error), 32'd0);
        check("t3_ovr", 32'(io_overrun), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 10, -1);
        repeat (5) @(negedge clock);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Framing error followed by a break, then a good frame
        send_frame(8'hFF, 1'b0, 10, -1);
        check("t4_ferr_before_stop", 32'(fhist[96]), 32'd0);
        check("t4_ferr_after_stop", 32'(fhist[97]), 32'd1);
        repeat (30) @(negedge clock);
        check("t4_no_valid", 32'(io_valid), 32'd0);
        io_rxd = 1'b1;
        repeat (20) @(negedge clock);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 10, -1);
        repeat (5) @(negedge clock);
        check("t4_ferr_sticky", 32'(io_frame_error), 32'd1);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame: outputs clear at once, next frame is clean
        send_frame(8'h33, 1'b1, 5, -1);
        reset = 1'b1;
        #1;
        check("t5_rst_data", {24'd0, io_data}, 32'd0);
        check("t5_rst_valid", 32'(io_valid), 32'd0);
        check("t5_rst_ferr", 32'(io_frame_error), 32'd0);
        check("t5_rst_ovr", 32'(io_overrun), 32'd0);
        io_rxd = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 10, -1);
        repeat (5) @(negedge clock);
        check("t5_ferr", 32'(io_frame_error), 32'd0);
        check("t5_ovr", 32'(io_overrun), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Consumer frees the slot in the exact stop-sample cycle
        io_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 10, -1);
        repeat (3) @(negedge clock);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 10, 96);
        check("t6_valid_at_sample", 32'(vhist[96]), 32'd1);
        check("t6_old_data", {24'd0, dhist[96]}, 32'h0000_0011);
        check("t6_valid_kept", 32'(vhist[97]), 32'd1);
        check("t6_new_data", {24'd0, dhist[97]}, 32'h0000_0022);
        check("t6_no_ovr_edge", 32'(ohist[97]), 32'd0);
        check("t6_no_ovr", 32'(io_overrun), 32'd0);
        repeat (5) @(negedge clock);
        check("t6_valid_drained", 32'(io_valid), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the UART transmit line (io_tx) driven by the Top SoC and recovers bytes for the simulation bench and the board loopback path.
- Sits directly downstream of Top's UART transmitter.
- Outputs received bytes through a one-entry valid/ready holding register.
- Reports framing errors and overruns as sticky flags.

Parameters:
- CLOCK_FREQ, 100000000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits per second.
- Derived CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer division).
- Derived HALF = CLKS_PER_BIT / 2.
- Synthesis/elaboration must fail if CLKS_PER_BIT < 4.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- io_rxd  input  1  serial line, idle high; connected to Top io_tx.
- io_data  output  8  received byte, valid while io_valid = 1.
- io_valid  output  1  holding register full.
- io_ready  input  1  consumer accepts io_data when io_valid && io_ready at a rising edge.
- io_clear  input  1  synchronous clear of both sticky error flags.
- io_frame_error  output  1  sticky: a stop bit was sampled low.
- io_overrun  output  1  sticky: a byte completed while the holding register was full and not being consumed.

Behaviour:
- Reset values (asynchronous, immediate):
  - io_data = 0, io_valid = 0, io_frame_error = 0, io_overrun = 0.
  - State = IDLE; counter = 0; bit index = 0; shift register = 0.
  - Both synchronizer flops = 1.
- Synchronizer: io_rxd passes through 2 flops; all decisions use the second flop (rx_s). Total input delay is 2 cycles.
- Frame format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). No parity.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - Stay while rx_s = 1.
  - When rx_s = 0, go to START with counter = 0.
- START:
  - counter increments each cycle.
  - At counter = HALF-1, sample rx_s.
  - If 0: go to DATA with counter = 0, bit index = 0.
  - If 1: false start, return to IDLE; no flags change.
- DATA:
  - At counter = CLKS_PER_BIT-1, sample rx_s into bit[index] and reset counter.
  - After index 7 is sampled, go to STOP.
  - Each bit is therefore sampled exactly CLKS_PER_BIT cycles after the previous sample.
- STOP: sample at counter = CLKS_PER_BIT-1.
  - rx_s = 1, holding empty, or holding full with io_ready = 1 in the same cycle:
    - Load the byte into io_data.
    - io_valid = 1 on the next cycle.
    - No overrun.
  - rx_s = 1, holding full and io_ready = 0:
    - Discard the new byte; io_data keeps the old byte.
    - Set io_overrun.
  - rx_s = 0:
    - Discard the byte; set io_frame_error.
    - Go to WAIT_IDLE.
  - On a valid stop bit, return to IDLE immediately after the sample cycle, so back-to-back frames are received.
- WAIT_IDLE: stay until rx_s = 1, then go to IDLE. A break condition therefore yields exactly one frame error.
- Handshake:
  - io_valid falls on the cycle after io_valid && io_ready, unless a new byte loads in that same cycle; then io_valid stays 1 with the new io_data.
  - io_data is stable while io_valid = 1 and not consumed.
- Sticky flags:
  - Cleared by io_clear = 1 at a clock edge.
  - If a set event and io_clear coincide, set wins.
- Latency: io_valid rises 1 cycle after the stop-bit sample cycle. That sample is 2 + (HALF-1) + 9·CLKS_PER_BIT cycles after the falling edge on io_rxd.
- Reset mid-frame: the partial byte is lost; no flags are set; the next complete frame is received normally.

Test Plan (CLOCK_FREQ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10; io_ready=1 unless stated):
- Send 0x55 -> io_valid pulses exactly 1 cycle with io_data=0x55; both flags stay 0; pulse occurs 2+4+90+1 = 97 cycles after the start edge.
- io_ready=0; send 0xA5 then 0x3C back-to-back -> io_data=0xA5 and io_valid held; io_overrun=1 after the second stop sample. Pulse io_clear -> io_overrun=0; io_data still 0xA5.
- Drive io_rxd low for 3 cycles, then high -> no io_valid; state returns to IDLE; both flags stay 0.
- Send 0xFF with stop bit 0, hold line low 30 cycles, then idle and send 0x12 -> io_frame_error=1 with no valid for 0xFF; next io_valid carries io_data=0x12.
- Assert reset after 4 data bits of 0x33 -> all outputs 0 immediately; then send 0x81 -> io_data=0x81 and no flags set.
- io_ready=0 with 0x11 held; raise io_ready in the exact stop-sample cycle of the next frame 0x22 -> io_valid stays 1; io_data=0x22 next cycle; io_overrun=0.
